// File: rtl/ddr_axi_pkg.sv
// ---------------------------------------------------------------------------
// ddr_axi_pkg
//   Shared definitions for the DDR AXI4 burst master:
//     state_t           - engine FSM states
//     AXI_BURST_INCR    - AXI INCR burst encoding
//     AXI_RESP_OKAY     - AXI OKAY response encoding
//     size_from_width() - AXI AxSIZE code for a data bus width in bits
// ---------------------------------------------------------------------------
package ddr_axi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_AW,
      ST_W,
      ST_B,
      ST_AR,
      ST_R
   } state_t;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   // AxSIZE = log2(bytes per beat); widths from 8 to 1024 bits are recognised.
   function automatic logic [2:0] size_from_width(input int data_w);
      logic [2:0] s;
      s = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if ((8 << i) == data_w) begin
            s = 3'(i);
         end
      end
      return s;
   endfunction

endpackage

// File: rtl/ddr_axi_master.sv
// ---------------------------------------------------------------------------
// ddr_axi_master
//   AXI4 master at the DDR end of the frame-buffer burst-request interface.
//   Accepts one write or read burst request at a time, drives the MIG AXI4
//   channels, pulls write beats from an FWFT write FIFO and pushes read beats
//   into the read FIFO. One burst in flight, single clock domain ui_clk.
//
//   Ports
//     ui_clk, ui_rst_n            clock, asynchronous active-low reset
//     calib_done                  MIG calibration complete; gates all grants
//     wr_/rd_brust_req/addr/len   burst requests (level, sampled in IDLE)
//     wr_ready / rd_ready         engine idle and calibrated
//     wr_fifo_re / wr_fifo_data   write FIFO pop / head (FWFT)
//     rd_fifo_we / rd_fifo_data   read FIFO push / data
//     wr_/rd_brust_finish         one-cycle burst completion pulses
//     m_axi_aw*, w*, b*, ar*, r*  AXI4 master channels
//     axi_err                     sticky: any non-OKAY BRESP/RRESP seen
//
//   Configuration macro
//     DDR_RD_PRIO_EN  defined: reads win every simultaneous request;
//                     undefined: simultaneous requests alternate (round-robin).
// ---------------------------------------------------------------------------
module ddr_axi_master
   import ddr_axi_pkg::*;
#(
   parameter int DATA_W  = 64,
   parameter int ADDR_W  = 32,
   parameter int MAX_LEN = 256
) (
   input  logic                ui_clk,
   input  logic                ui_rst_n,
   input  logic                calib_done,
   input  logic                wr_brust_req,
   input  logic [ADDR_W-1:0]   wr_brust_addr,
   input  logic [9:0]          wr_brust_len,
   input  logic                rd_brust_req,
   input  logic [ADDR_W-1:0]   rd_brust_addr,
   input  logic [9:0]          rd_brust_len,
   output logic                wr_ready,
   output logic                rd_ready,
   output logic                wr_fifo_re,
   input  logic [DATA_W-1:0]   wr_fifo_data,
   output logic                wr_brust_finish,
   output logic                rd_brust_finish,
   output logic                rd_fifo_we,
   output logic [DATA_W-1:0]   rd_fifo_data,
   output logic [ADDR_W-1:0]   m_axi_awaddr,
   output logic [7:0]          m_axi_awlen,
   output logic [2:0]          m_axi_awsize,
   output logic [1:0]          m_axi_awburst,
   output logic                m_axi_awvalid,
   input  logic                m_axi_awready,
   output logic [DATA_W-1:0]   m_axi_wdata,
   output logic [DATA_W/8-1:0] m_axi_wstrb,
   output logic                m_axi_wlast,
   output logic                m_axi_wvalid,
   input  logic                m_axi_wready,
   input  logic [1:0]          m_axi_bresp,
   input  logic                m_axi_bvalid,
   output logic                m_axi_bready,
   output logic [ADDR_W-1:0]   m_axi_araddr,
   output logic [7:0]          m_axi_arlen,
   output logic [2:0]          m_axi_arsize,
   output logic [1:0]          m_axi_arburst,
   output logic                m_axi_arvalid,
   input  logic                m_axi_arready,
   input  logic [DATA_W-1:0]   m_axi_rdata,
   input  logic [1:0]          m_axi_rresp,
   input  logic                m_axi_rlast,
   input  logic                m_axi_rvalid,
   output logic                m_axi_rready,
   output logic                axi_err
);

   localparam int         STRB_W    = DATA_W / 8;
   localparam logic [2:0] AXI_SIZE  = size_from_width(DATA_W);
   localparam logic [9:0] MAX_LEN_L = 10'(MAX_LEN);

   // AXI length field (beats - 1) with len 0 promoted to 1 and long bursts clamped.
   function automatic logic [7:0] axi_len(input logic [9:0] l);
      if (l == 10'd0) begin
         return 8'd0;
      end else if (l > MAX_LEN_L) begin
         return 8'(MAX_LEN_L - 10'd1);
      end else begin
         return 8'(l - 10'd1);
      end
   endfunction

   state_t            state_q, state_d;
   logic              last_rd_q, last_rd_d;   // previous grant went to the read side
   logic [ADDR_W-1:0] addr_q, addr_d;         // shared by AW and AR: one burst in flight
   logic [7:0]        alen_q, alen_d;
   logic [9:0]        beat_q, beat_d;
   logic              ready_q, ready_d;
   logic              awvalid_q, awvalid_d;
   logic              wvalid_q, wvalid_d;
   logic              wlast_q, wlast_d;
   logic              bready_q, bready_d;
   logic              arvalid_q, arvalid_d;
   logic              rready_q, rready_d;
   logic              wr_fin_q, wr_fin_d;
   logic              rd_fin_q, rd_fin_d;
   logic              err_q, err_d;
   logic              grant_wr, grant_rd;
   logic              w_hs, r_hs;

   assign w_hs = wvalid_q & m_axi_wready;
   assign r_hs = rready_q & m_axi_rvalid;

   always_comb begin
      grant_wr = 1'b0;
      grant_rd = 1'b0;
      if (state_q == ST_IDLE && calib_done) begin
         if (wr_brust_req && rd_brust_req) begin
`ifdef DDR_RD_PRIO_EN
            grant_rd = 1'b1;
`else
            grant_wr = last_rd_q;
            grant_rd = ~last_rd_q;
`endif
         end else begin
            grant_wr = wr_brust_req;
            grant_rd = rd_brust_req;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      last_rd_d = last_rd_q;
      addr_d    = addr_q;
      alen_d    = alen_q;
      beat_d    = beat_q;
      err_d     = err_q;
      wr_fin_d  = 1'b0;
      rd_fin_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (grant_wr) begin
               state_d   = ST_AW;
               last_rd_d = 1'b0;
               addr_d    = wr_brust_addr;
               alen_d    = axi_len(wr_brust_len);
               beat_d    = 10'd0;
            end else if (grant_rd) begin
               state_d   = ST_AR;
               last_rd_d = 1'b1;
               addr_d    = rd_brust_addr;
               alen_d    = axi_len(rd_brust_len);
               beat_d    = 10'd0;
            end
         end
         ST_AW: if (awvalid_q && m_axi_awready) state_d = ST_W;
         ST_W: begin
            if (w_hs) begin
               beat_d = beat_q + 10'd1;
               if (wlast_q) state_d = ST_B;
            end
         end
         ST_B: begin
            if (m_axi_bvalid) begin
               wr_fin_d = 1'b1;
               state_d  = ST_IDLE;
               if (m_axi_bresp != AXI_RESP_OKAY) err_d = 1'b1;
            end
         end
         ST_AR: if (arvalid_q && m_axi_arready) state_d = ST_R;
         ST_R: begin
            // Read termination follows the slave's RLAST, not the beat count.
            if (r_hs) begin
               beat_d = beat_q + 10'd1;
               if (m_axi_rresp != AXI_RESP_OKAY) err_d = 1'b1;
               if (m_axi_rlast) begin
                  rd_fin_d = 1'b1;
                  state_d  = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Channel controls are registered from the next state so they line up
      // with the state they belong to.
      ready_d   = (state_d == ST_IDLE) && calib_done;
      awvalid_d = (state_d == ST_AW);
      wvalid_d  = (state_d == ST_W);
      wlast_d   = (state_d == ST_W) && (beat_d == {2'b00, alen_d});
      bready_d  = (state_d == ST_B);
      arvalid_d = (state_d == ST_AR);
      rready_d  = (state_d == ST_R);
   end

   always_ff @(posedge ui_clk or negedge ui_rst_n) begin
      if (!ui_rst_n) begin
         state_q   <= ST_IDLE;
         last_rd_q <= 1'b1;
         addr_q    <= '0;
         alen_q    <= '0;
         beat_q    <= '0;
         ready_q   <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         wlast_q   <= 1'b0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         wr_fin_q  <= 1'b0;
         rd_fin_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_rd_q <= last_rd_d;
         addr_q    <= addr_d;
         alen_q    <= alen_d;
         beat_q    <= beat_d;
         ready_q   <= ready_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         wlast_q   <= wlast_d;
         bready_q  <= bready_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         wr_fin_q  <= wr_fin_d;
         rd_fin_q  <= rd_fin_d;
         err_q     <= err_d;
      end
   end

   assign wr_ready        = ready_q;
   assign rd_ready        = ready_q;
   assign wr_brust_finish = wr_fin_q;
   assign rd_brust_finish = rd_fin_q;
   assign axi_err         = err_q;

   // FWFT head is presented directly; the pop coincides with the W handshake.
   assign wr_fifo_re    = w_hs;
   assign m_axi_wdata   = {DATA_W{wvalid_q}} & wr_fifo_data;
   assign m_axi_wstrb   = {STRB_W{wvalid_q}};
   assign m_axi_wlast   = wlast_q;
   assign m_axi_wvalid  = wvalid_q;

   assign m_axi_awaddr  = addr_q;
   assign m_axi_awlen   = alen_q;
   assign m_axi_awsize  = awvalid_q ? AXI_SIZE : 3'd0;
   assign m_axi_awburst = awvalid_q ? AXI_BURST_INCR : 2'd0;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_bready  = bready_q;

   assign m_axi_araddr  = addr_q;
   assign m_axi_arlen   = alen_q;
   assign m_axi_arsize  = arvalid_q ? AXI_SIZE : 3'd0;
   assign m_axi_arburst = arvalid_q ? AXI_BURST_INCR : 2'd0;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_rready  = rready_q;

   assign rd_fifo_we    = r_hs;
   assign rd_fifo_data  = m_axi_rdata;

endmodule

// File: tb/tb_ddr_axi_master.sv
module tb_ddr_axi_master;

   logic        ui_clk = 1'b0;
   logic        ui_rst_n;
   logic        calib_done;
   logic        wr_brust_req, rd_brust_req;
   logic [31:0] wr_brust_addr, rd_brust_addr;
   logic [9:0]  wr_brust_len, rd_brust_len;
   logic        wr_ready, rd_ready, wr_fifo_re, rd_fifo_we;
   logic [63:0] wr_fifo_data, rd_fifo_data;
   logic        wr_brust_finish, rd_brust_finish, axi_err;
   logic [31:0] m_axi_awaddr, m_axi_araddr;
   logic [7:0]  m_axi_awlen, m_axi_arlen;
   logic [2:0]  m_axi_awsize, m_axi_arsize;
   logic [1:0]  m_axi_awburst, m_axi_arburst;
   logic        m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
   logic [63:0] m_axi_wdata, m_axi_rdata;
   logic [7:0]  m_axi_wstrb;
   logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
   logic [1:0]  m_axi_bresp, m_axi_rresp;
   logic        m_axi_bvalid, m_axi_bready;
   logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

   ddr_axi_master dut (
      .ui_clk(ui_clk), .ui_rst_n(ui_rst_n), .calib_done(calib_done),
      .wr_brust_req(wr_brust_req), .wr_brust_addr(wr_brust_addr), .wr_brust_len(wr_brust_len),
      .rd_brust_req(rd_brust_req), .rd_brust_addr(rd_brust_addr), .rd_brust_len(rd_brust_len),
      .wr_ready(wr_ready), .rd_ready(rd_ready),
      .wr_fifo_re(wr_fifo_re), .wr_fifo_data(wr_fifo_data),
      .wr_brust_finish(wr_brust_finish), .rd_brust_finish(rd_brust_finish),
      .rd_fifo_we(rd_fifo_we), .rd_fifo_data(rd_fifo_data),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
      .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
      .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
      .axi_err(axi_err)
   );

   initial forever #5 ui_clk = ~ui_clk;

   typedef struct {
      bit          is_wr;
      logic [31:0] addr;
      int          len;
   } exp_t;

   typedef struct {
      bit          is_wr;
      logic [31:0] addr;
      logic [9:0]  len;
      bit          stall;
      bit          rtog;
      int          exp_len;
   } vec_t;

   exp_t exp_q[$];
   exp_t cur;
   vec_t vecs[9];

   int checks = 0;
   int errors = 0;

   // slave / FIFO model controls
   bit       stall_en = 0;
   bit       rtoggle = 0;
   logic [1:0] bresp_cfg = 2'b00;

   // monitor state
   int wbeats, rbeats, mon_pops;
   bit wr_fin_exp, rd_fin_exp, err_model;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // AXI slave and FWFT write FIFO model: sample just before the edge, drive just after it.
   initial begin
      bit s_wlast, s_b, s_ar, s_r, s_pop;
      logic [7:0]  s_alen;
      logic [31:0] s_aaddr, rd_base;
      int rd_left, rd_idx, pop_cnt;
      bit b_pend;
      rd_left = 0; rd_idx = 0; pop_cnt = 0; b_pend = 0; rd_base = '0;
      forever begin
         @(negedge ui_clk);
         s_wlast = m_axi_wvalid && m_axi_wready && m_axi_wlast;
         s_b     = m_axi_bvalid && m_axi_bready;
         s_ar    = m_axi_arvalid && m_axi_arready;
         s_r     = m_axi_rvalid && m_axi_rready;
         s_pop   = wr_fifo_re;
         s_alen  = m_axi_arlen;
         s_aaddr = m_axi_araddr;
         @(posedge ui_clk);
         #1;
         if (!ui_rst_n) begin
            rd_left = 0; b_pend = 0; pop_cnt = 0;
            m_axi_bvalid = 0; m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rdata = '0;
         end else begin
            if (s_pop) pop_cnt++;
            if (s_wlast) b_pend = 1;
            if (s_b) m_axi_bvalid = 0;
            if (b_pend && !m_axi_bvalid) begin
               m_axi_bvalid = 1; m_axi_bresp = bresp_cfg; b_pend = 0;
            end
            if (s_ar) begin rd_left = int'(s_alen) + 1; rd_idx = 0; rd_base = s_aaddr; end
            if (s_r) begin rd_idx++; rd_left--; end
            m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rdata = '0;
            if (rd_left > 0 && (!rtoggle || $urandom_range(0, 1) == 1)) begin
               m_axi_rvalid = 1;
               m_axi_rdata  = {rd_base, 32'(rd_idx)};
               m_axi_rlast  = (rd_left == 1);
            end
         end
         wr_fifo_data  = {32'hF1F0_0000, 32'(pop_cnt)};
         m_axi_awready = !stall_en || ($urandom_range(0, 1) == 1);
         m_axi_wready  = !stall_en || ($urandom_range(0, 1) == 1);
         m_axi_arready = !stall_en || ($urandom_range(0, 1) == 1);
      end
   end

   // Monitor / scoreboard: address handshakes pop the expected burst, data
   // and completion are checked against it.
   initial begin
      wbeats = 0; rbeats = 0; mon_pops = 0; wr_fin_exp = 0; rd_fin_exp = 0; err_model = 0;
      forever begin
         @(negedge ui_clk);
         if (!ui_rst_n) begin
            exp_q.delete();
            wbeats = 0; rbeats = 0; mon_pops = 0;
            wr_fin_exp = 0; rd_fin_exp = 0; err_model = 0;
         end else begin
            if (wr_fin_exp || wr_brust_finish) begin
               chk("wr_finish", 64'(wr_brust_finish), 64'(wr_fin_exp));
               if (wr_fin_exp) chk("wr_beats", 64'(wbeats), 64'(cur.len));
            end
            if (rd_fin_exp || rd_brust_finish) begin
               chk("rd_finish", 64'(rd_brust_finish), 64'(rd_fin_exp));
               if (rd_fin_exp) chk("rd_beats", 64'(rbeats), 64'(cur.len));
            end
            if (err_model || axi_err) chk("axi_err", 64'(axi_err), 64'(err_model));
            wr_fin_exp = m_axi_bvalid && m_axi_bready;
            rd_fin_exp = m_axi_rvalid && m_axi_rready && m_axi_rlast;
            if ((m_axi_awvalid && m_axi_awready) || (m_axi_arvalid && m_axi_arready)) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_addr_hs", 64'(1), 64'(0));
               end else begin
                  cur = exp_q.pop_front();
                  wbeats = 0; rbeats = 0;
                  chk("grant_dir", 64'(m_axi_awvalid), 64'(cur.is_wr));
                  if (m_axi_awvalid) begin
                     chk("awaddr", 64'(m_axi_awaddr), 64'(cur.addr));
                     chk("awlen", 64'(m_axi_awlen), 64'(cur.len - 1));
                     chk("awsize_burst", 64'({m_axi_awsize, m_axi_awburst}), 64'({3'd3, 2'b01}));
                  end else begin
                     chk("araddr", 64'(m_axi_araddr), 64'(cur.addr));
                     chk("arlen", 64'(m_axi_arlen), 64'(cur.len - 1));
                     chk("arsize_burst", 64'({m_axi_arsize, m_axi_arburst}), 64'({3'd3, 2'b01}));
                  end
               end
            end
            if (m_axi_wvalid && m_axi_wready) begin
               chk("wr_fifo_re", 64'(wr_fifo_re), 64'(1));
               chk("wdata", m_axi_wdata, {32'hF1F0_0000, 32'(mon_pops)});
               chk("wstrb", 64'(m_axi_wstrb), 64'(8'hFF));
               chk("wlast", 64'(m_axi_wlast), 64'(wbeats == cur.len - 1));
               wbeats++; mon_pops++;
            end else if (wr_fifo_re) begin
               chk("wr_fifo_re_spurious", 64'(wr_fifo_re), 64'(0));
            end
            if (m_axi_bvalid && m_axi_bready && m_axi_bresp != 2'b00) err_model = 1;
            if (m_axi_rvalid && m_axi_rready) begin
               chk("rd_fifo_we", 64'(rd_fifo_we), 64'(1));
               chk("rd_fifo_data", rd_fifo_data, {cur.addr, 32'(rbeats)});
               if (m_axi_rresp != 2'b00) err_model = 1;
               rbeats++;
            end else if (rd_fifo_we) begin
               chk("rd_fifo_we_spurious", 64'(rd_fifo_we), 64'(0));
            end
         end
      end
   end

   // Called just after a negedge: wait for ready, present the request, drop it after grant.
   task automatic start_req(input bit is_wr, input logic [31:0] a, input logic [9:0] l,
                            input int exp_len);
      int n;
      exp_t e;
      n = 0;
      while (!(is_wr ? wr_ready : rd_ready) && n < 200) begin
         @(negedge ui_clk);
         n++;
      end
      chk("ready_wait_timeout", 64'(n >= 200), 64'(0));
      e.is_wr = is_wr; e.addr = a; e.len = exp_len;
      exp_q.push_back(e);
      if (is_wr) begin wr_brust_addr = a; wr_brust_len = l; wr_brust_req = 1; end
      else       begin rd_brust_addr = a; rd_brust_len = l; rd_brust_req = 1; end
      @(negedge ui_clk);
      chk("ready_drop_after_grant", 64'({wr_ready, rd_ready}), 64'(0));
      wr_brust_req = 0; rd_brust_req = 0;
   endtask

   task automatic wait_finish();
      int n;
      n = 0;
      do begin
         @(negedge ui_clk);
         n++;
      end while (!(wr_brust_finish || rd_brust_finish) && n < 3000);
      chk("finish_timeout", 64'(n >= 3000), 64'(0));
   endtask

   task automatic reset_dut();
      @(negedge ui_clk);
      ui_rst_n = 0;
      repeat (2) @(negedge ui_clk);
      ui_rst_n = 1;
      @(negedge ui_clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nfin, n;
      vecs[0] = '{1, 32'h0000_0100,  10'd4,   0, 0, 4};
      vecs[1] = '{0, 32'h0000_2000,  10'd8,   0, 1, 8};
      vecs[2] = '{1, 32'h0000_0300,  10'd0,   0, 0, 1};
      vecs[3] = '{0, 32'h0000_4000,  10'd300, 0, 0, 256};
      vecs[4] = '{1, 32'h0000_0500,  10'd16,  1, 0, 16};
      vecs[5] = '{0, 32'h0000_0600,  10'd256, 1, 1, 256};
      vecs[6] = '{1, 32'h0000_0800,  10'd1,   0, 0, 1};
      vecs[7] = '{0, 32'h0000_0900,  10'd1,   1, 1, 1};
      vecs[8] = '{1, 32'h0000_0A00,  10'd257, 1, 0, 256};

      ui_rst_n = 0; calib_done = 0;
      wr_brust_req = 0; rd_brust_req = 0;
      wr_brust_addr = '0; rd_brust_addr = '0; wr_brust_len = '0; rd_brust_len = '0;
      wr_fifo_data = '0;
      m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
      m_axi_bresp = 2'b00; m_axi_bvalid = 0;
      m_axi_rdata = '0; m_axi_rresp = 2'b00; m_axi_rlast = 0; m_axi_rvalid = 0;

      // reset state
      repeat (3) @(negedge ui_clk);
      chk("rst_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready,
                              m_axi_rready, wr_fifo_re, rd_fifo_we}), 64'(0));
      chk("rst_ready", 64'({wr_ready, rd_ready}), 64'(0));
      chk("rst_finish_err", 64'({wr_brust_finish, rd_brust_finish, axi_err}), 64'(0));
      chk("rst_addr", 64'({m_axi_awaddr, m_axi_araddr}), 64'(0));
      ui_rst_n = 1;
      @(negedge ui_clk);
      chk("ready_wo_calib", 64'({wr_ready, rd_ready}), 64'(0));
      calib_done = 1;
      @(negedge ui_clk);
      chk("ready_calib", 64'({wr_ready, rd_ready}), 64'(2'b11));

      // table-driven bursts
      for (int i = 0; i < 9; i++) begin
         stall_en = vecs[i].stall;
         rtoggle  = vecs[i].rtog;
         start_req(vecs[i].is_wr, vecs[i].addr, vecs[i].len, vecs[i].exp_len);
         wait_finish();
         $display("txn %0d %s addr=0x%0h len=%0d eff=%0d", i, vecs[i].is_wr ? "WR" : "RD",
                  vecs[i].addr, vecs[i].len, vecs[i].exp_len);
      end
      stall_en = 0; rtoggle = 0;

      // error response on a write is sticky; finish still pulses
      bresp_cfg = 2'b10;
      start_req(1, 32'h0000_1000, 10'd2, 2);
      wait_finish();
      bresp_cfg = 2'b00;
      chk("axi_err_set", 64'(axi_err), 64'(1));
      $display("txn err WR addr=0x1000 len=2 bresp=2");
      start_req(0, 32'h0000_1100, 10'd4, 4);
      wait_finish();
      chk("axi_err_sticky", 64'(axi_err), 64'(1));
      $display("txn err RD addr=0x1100 len=4");

      // simultaneous requests, starting from reset (last grant = read)
      reset_dut();
      begin
         exp_t e;
         for (int k = 0; k < 4; k++) begin
`ifdef DDR_RD_PRIO_EN
            e.is_wr = 0;
`else
            e.is_wr = (k % 2 == 0);
`endif
            e.addr = e.is_wr ? 32'h0000_6000 : 32'h0000_7000;
            e.len  = 2;
            exp_q.push_back(e);
         end
      end
      wr_brust_addr = 32'h0000_6000; wr_brust_len = 10'd2;
      rd_brust_addr = 32'h0000_7000; rd_brust_len = 10'd2;
      wr_brust_req = 1; rd_brust_req = 1;
      nfin = 0; n = 0;
      while (nfin < 4 && n < 2000) begin
         @(negedge ui_clk);
         n++;
         if (wr_brust_finish || rd_brust_finish) begin
            nfin++;
            $display("txn rr %0d %s", nfin, wr_brust_finish ? "WR" : "RD");
            if (nfin == 4) begin wr_brust_req = 0; rd_brust_req = 0; end
         end
      end
      wr_brust_req = 0; rd_brust_req = 0;
      chk("rr_finish_count", 64'(nfin), 64'(4));
      repeat (20) @(negedge ui_clk);
      chk("rr_queue_empty", 64'(exp_q.size()), 64'(0));
      chk("rr_idle_ready", 64'({wr_ready, rd_ready}), 64'(2'b11));

      // reset during write beat 2
      start_req(1, 32'h0000_0C00, 10'd8, 8);
      n = 0;
      while (n < 200) begin
         @(negedge ui_clk);
         #1;
         if (wbeats >= 2) break;
         n++;
      end
      chk("beat2_reached", 64'(wbeats >= 2), 64'(1));
      #1 ui_rst_n = 0;
      #1;
      chk("midrst_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready,
                                 m_axi_rready, wr_fifo_re}), 64'(0));
      chk("midrst_finish", 64'({wr_brust_finish, rd_brust_finish}), 64'(0));
      $display("txn midrst WR addr=0xc00 len=8 reset after beat 2");
      calib_done = 0;
      repeat (3) @(negedge ui_clk);
      ui_rst_n = 1;
      wr_brust_req = 1; wr_brust_addr = 32'h0000_0D00; wr_brust_len = 10'd4;
      for (int k = 0; k < 8; k++) begin
         @(negedge ui_clk);
         chk("nocalib_blocked", 64'({wr_ready, rd_ready, m_axi_awvalid, wr_brust_finish}), 64'(0));
      end
      wr_brust_req = 0;
      calib_done = 1;
      @(negedge ui_clk);
      chk("calib_ready", 64'({wr_ready, rd_ready}), 64'(2'b11));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
